// File: rtl/issue_hazard_scheduler.sv
// issue_hazard_scheduler
//   Issue-stage controller for the 5-stage RV32I pipeline. Decides each cycle
//   whether the decoded instruction may advance into execute. It uses a
//   32-entry register scoreboard to block RAW and WAW hazards against writes
//   still in flight, and it sequences a branch stall/flush.
//
//   Optional feature: define ISSUE_WB_BYPASS_EN to let a source operand issue
//   in the same cycle as the writeback that produces it. The rd (WAW) check
//   is never bypassed.
//
// Ports
//   clk, rst            clock (rising edge); asynchronous active-high reset
//   id_*                decoded instruction: valid, rs1/rs2 (+used), rd (+we), branch
//   wb_valid, wb_rd     RegisterFile writeback this cycle
//   br_resolve_valid,
//   br_taken            branch outcome from execute
//   issue, stall        combinational issue decision and its complement qualified by id_valid
//   flush               registered one-cycle IF/ID kill
//   pending             registered scoreboard mask (bit 0 always 0)
//   outstanding         number of set pending bits
//   stall_count         saturating count of stall cycles
module issue_hazard_scheduler #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned STALL_CNT_W     = 16
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       id_valid,
    input  logic [4:0]                                 id_rs1,
    input  logic                                       id_rs1_used,
    input  logic [4:0]                                 id_rs2,
    input  logic                                       id_rs2_used,
    input  logic [4:0]                                 id_rd,
    input  logic                                       id_rd_we,
    input  logic                                       id_is_branch,
    input  logic                                       wb_valid,
    input  logic [4:0]                                 wb_rd,
    input  logic                                       br_resolve_valid,
    input  logic                                       br_taken,
    output logic                                       issue,
    output logic                                       stall,
    output logic                                       flush,
    output logic [31:0]                                pending,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       outstanding,
    output logic [STALL_CNT_W-1:0]                     stall_count
);

    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_BR_WAIT = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    state_t      state;
    logic        rs1_haz;
    logic        rs2_haz;
    logic        rd_haz;
    logic        hazard;
    logic        full;
    logic        set_en;
    logic        clr_en;
    logic [31:0] pending_nxt;

    // Hazard detection; pending[0] is held at 0 so x0 never matches.
    always_comb begin
        rs1_haz = id_rs1_used && pending[id_rs1];
        rs2_haz = id_rs2_used && pending[id_rs2];
`ifdef ISSUE_WB_BYPASS_EN
        // The forward path supplies a value written back this very cycle.
        if (wb_valid && (wb_rd == id_rs1)) rs1_haz = 1'b0;
        if (wb_valid && (wb_rd == id_rs2)) rs2_haz = 1'b0;
`endif
        rd_haz = id_rd_we && pending[id_rd];
        hazard = rs1_haz || rs2_haz || rd_haz;
        full   = (outstanding == OUT_W'(MAX_OUTSTANDING)) && id_rd_we && (id_rd != 5'd0);
        issue  = id_valid && (state == ST_RUN) && !hazard && !full;
        stall  = id_valid && !issue;
    end

    // Scoreboard next value. A set and a clear on the same index leave the
    // bit set: the writeback belongs to an older writer.
    always_comb begin
        set_en      = issue && id_rd_we && (id_rd != 5'd0);
        clr_en      = wb_valid && (wb_rd != 5'd0) && pending[wb_rd]
                      && !(set_en && (id_rd == wb_rd));
        pending_nxt = pending;
        if (clr_en) pending_nxt[wb_rd] = 1'b0;
        if (set_en) pending_nxt[id_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    // Branch FSM, scoreboard, occupancy and stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_RUN;
            flush       <= 1'b0;
            pending     <= '0;
            outstanding <= '0;
            stall_count <= '0;
        end else begin
            pending <= pending_nxt;

            case ({set_en, clr_en})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase

            if (stall && (stall_count != {STALL_CNT_W{1'b1}})) begin
                stall_count <= stall_count + STALL_CNT_W'(1);
            end

            flush <= 1'b0;
            case (state)
                ST_RUN: begin
                    // Resolutions seen here belong to no waiting branch.
                    if (issue && id_is_branch) state <= ST_BR_WAIT;
                end
                ST_BR_WAIT: begin
                    if (br_resolve_valid) begin
                        if (br_taken) begin
                            state <= ST_FLUSH;
                            flush <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_FLUSH: begin
                    state <= ST_RUN;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_issue_hazard_scheduler.sv
module tb_issue_hazard_scheduler;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic        id_rs1_used;
    logic [4:0]  id_rs2;
    logic        id_rs2_used;
    logic [4:0]  id_rd;
    logic        id_rd_we;
    logic        id_is_branch;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        br_resolve_valid;
    logic        br_taken;
    logic        issue;
    logic        stall;
    logic        flush;
    logic [31:0] pending;
    logic [2:0]  outstanding;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;
    int exp_sc = 0;

    issue_hazard_scheduler #(
        .MAX_OUTSTANDING(4),
        .STALL_CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .id_valid(id_valid),
        .id_rs1(id_rs1),
        .id_rs1_used(id_rs1_used),
        .id_rs2(id_rs2),
        .id_rs2_used(id_rs2_used),
        .id_rd(id_rd),
        .id_rd_we(id_rd_we),
        .id_is_branch(id_is_branch),
        .wb_valid(wb_valid),
        .wb_rd(wb_rd),
        .br_resolve_valid(br_resolve_valid),
        .br_taken(br_taken),
        .issue(issue),
        .stall(stall),
        .flush(flush),
        .pending(pending),
        .outstanding(outstanding),
        .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic we, input logic br);
        id_valid     = v;
        id_rs1       = rs1;
        id_rs1_used  = u1;
        id_rs2       = rs2;
        id_rs2_used  = u2;
        id_rd        = rd;
        id_rd_we     = we;
        id_is_branch = br;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] rd);
        wb_valid = v;
        wb_rd    = rd;
    endtask

    task automatic set_br(input logic v, input logic t);
        br_resolve_valid = v;
        br_taken         = t;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        set_wb(1'b0, 5'd0);
        set_br(1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        settle();
        chk("reset_pending", pending, 32'h0);
        chk("reset_outstanding", 32'(outstanding), 32'd0);
        chk("reset_flush", 32'(flush), 32'd0);
        chk("reset_stall_count", 32'(stall_count), 32'd0);
        chk("idle_issue", 32'(issue), 32'd0);
        chk("idle_stall", 32'(stall), 32'd0);

        // RAW: write x2, then a reader of x2 waits for writeback.
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0);
        settle();
        chk("raw_writer_issue", 32'(issue), 32'd1);
        tick();
        set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        settle();
        chk("raw_pending_x2", pending, 32'h0000_0004);
        chk("raw_outstanding", 32'(outstanding), 32'd1);
        chk("raw_stall_c1", 32'(stall), 32'd1);
        tick(); exp_sc++;
        settle();
        chk("raw_stall_c2", 32'(stall), 32'd1);
        chk("raw_sc_c2", 32'(stall_count), 32'(exp_sc));
        tick(); exp_sc++;
        set_wb(1'b1, 5'd2);
        settle();
`ifdef ISSUE_WB_BYPASS_EN
        chk("raw_issue_wb_cycle", 32'(issue), 32'd1);
        tick();
        set_wb(1'b0, 5'd0);
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        settle();
        chk("raw_pending_cleared", pending, 32'h0);
        chk("raw_sc_final", 32'(stall_count), 32'd2);
`else
        chk("raw_issue_wb_cycle", 32'(issue), 32'd0);
        tick(); exp_sc++;
        set_wb(1'b0, 5'd0);
        settle();
        chk("raw_issue_after_wb", 32'(issue), 32'd1);
        chk("raw_pending_cleared", pending, 32'h0);
        chk("raw_sc_final", 32'(stall_count), 32'd3);
        tick();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        settle();
`endif
        chk("raw_outstanding_zero", 32'(outstanding), 32'd0);

        // x0 destination never enters the scoreboard; spurious writeback is harmless.
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        settle();
        chk("x0_issue", 32'(issue), 32'd1);
        tick();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        set_wb(1'b1, 5'd5);
        settle();
        chk("x0_pending", pending, 32'h0);
        tick();
        set_wb(1'b0, 5'd0);
        settle();
        chk("spurious_wb_outstanding", 32'(outstanding), 32'd0);
        chk("spurious_wb_pending", pending, 32'h0);

        // Full: four writers x1..x4, a fifth to x5 waits for any writeback.
        for (int r = 1; r <= 4; r++) begin
            set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(r), 1'b1, 1'b0);
            settle();
            chk("full_fill_issue", 32'(issue), 32'd1);
            tick();
        end
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        settle();
        chk("full_pending", pending, 32'h0000_001E);
        chk("full_outstanding_4", 32'(outstanding), 32'd4);
        chk("full_stall", 32'(stall), 32'd1);
        tick(); exp_sc++;
        set_wb(1'b1, 5'd1);
        settle();
        chk("full_stall_wb_cycle", 32'(issue), 32'd0);
        tick(); exp_sc++;
        set_wb(1'b0, 5'd0);
        settle();
        chk("full_outstanding_3", 32'(outstanding), 32'd3);
        chk("full_issue_after_wb", 32'(issue), 32'd1);
        tick();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        settle();
        chk("full_outstanding_4b", 32'(outstanding), 32'd4);
        chk("full_pending_b", pending, 32'h0000_003C);
        chk("full_sc", 32'(stall_count), 32'(exp_sc));
        for (int r = 2; r <= 5; r++) begin
            set_wb(1'b1, 5'(r));
            tick();
        end
        set_wb(1'b0, 5'd0);
        settle();
        chk("drain_outstanding", 32'(outstanding), 32'd0);
        chk("drain_pending", pending, 32'h0);

        // Set and clear on the same index in one cycle: set wins.
        // x7 is not pending, so the writeback is not an effective clear.
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        set_wb(1'b1, 5'd7);
        settle();
        chk("setclr_issue", 32'(issue), 32'd1);
        tick();
        set_wb(1'b0, 5'd0);
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        settle();
        chk("setclr_pending", pending, 32'h0000_0080);
        chk("setclr_outstanding", 32'(outstanding), 32'd1);
        // A second writer of x7 is WAW-blocked while the older write retires.
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        set_wb(1'b1, 5'd7);
        settle();
        chk("waw_stall", 32'(stall), 32'd1);
        tick(); exp_sc++;
        set_wb(1'b0, 5'd0);
        settle();
        chk("waw_issue_after", 32'(issue), 32'd1);
        chk("waw_outstanding_mid", 32'(outstanding), 32'd0);
        tick();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        set_wb(1'b1, 5'd7);
        settle();
        chk("waw_pending", pending, 32'h0000_0080);
        chk("waw_outstanding", 32'(outstanding), 32'd1);
        tick();
        set_wb(1'b0, 5'd0);
        settle();
        chk("x7_cleared", pending, 32'h0);

        // Taken branch: resolve in the issue cycle is ignored, then 3 wait cycles.
        set_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1);
        set_br(1'b1, 1'b1);
        settle();
        chk("br_issue", 32'(issue), 32'd1);
        tick();
        set_br(1'b0, 1'b0);
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("br_wait_issue", 32'(issue), 32'd0);
            chk("br_wait_flush", 32'(flush), 32'd0);
            tick(); exp_sc++;
        end
        set_br(1'b1, 1'b1);
        settle();
        chk("br_resolve_issue", 32'(issue), 32'd0);
        tick(); exp_sc++;
        set_br(1'b0, 1'b0);
        settle();
        chk("br_flush_high", 32'(flush), 32'd1);
        chk("br_flush_issue", 32'(issue), 32'd0);
        tick(); exp_sc++;
        settle();
        chk("br_flush_low", 32'(flush), 32'd0);
        chk("br_run_issue", 32'(issue), 32'd1);
        chk("br_sc", 32'(stall_count), 32'(exp_sc));
        tick();

        // Not-taken branch: no flush, issue resumes the next cycle.
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        settle();
        chk("nt_br_issue", 32'(issue), 32'd1);
        tick();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        settle();
        chk("nt_wait_issue", 32'(issue), 32'd0);
        tick(); exp_sc++;
        set_br(1'b1, 1'b0);
        settle();
        chk("nt_resolve_issue", 32'(issue), 32'd0);
        tick(); exp_sc++;
        set_br(1'b0, 1'b0);
        settle();
        chk("nt_no_flush", 32'(flush), 32'd0);
        chk("nt_issue_resumes", 32'(issue), 32'd1);
        chk("nt_sc", 32'(stall_count), 32'(exp_sc));
        tick();

        // Asynchronous reset in BR_WAIT with pending = 0x6.
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        settle();
        chk("rst_br_issue", 32'(issue), 32'd1);
        tick();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        settle();
        chk("rst_pre_pending", pending, 32'h0000_0006);
        chk("rst_pre_issue", 32'(issue), 32'd0);
        rst = 1'b1;
        settle();
        chk("arst_pending", pending, 32'h0);
        chk("arst_outstanding", 32'(outstanding), 32'd0);
        chk("arst_flush", 32'(flush), 32'd0);
        chk("arst_stall_count", 32'(stall_count), 32'd0);
        chk("arst_state_run", 32'(issue), 32'd1);
        tick();
        rst = 1'b0;
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        settle();
        chk("post_rst_stall", 32'(stall), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
